// File: rtl/div_sched_if.sv
`default_nettype none
// ============================================================================
//  Module   : div_sched_if
//  Purpose  : Bundle of request/grant and divider-control signals between
//             client logic, the div_sched scheduler and the shared divider.
//  Ports    : req[1:0], ratio0/1, len0/1, div_tick   -> into scheduler
//             gnt[1:0], done[1:0], aborted, busy,
//             div_en, div_sel, div_clr               <- from scheduler
//  Revision : 1.0  initial release
// ============================================================================
interface div_sched_if #(
    parameter int CNT_W = 8
) ();
    logic [1:0]       req;
    logic             ratio0;
    logic             ratio1;
    logic [CNT_W-1:0] len0;
    logic [CNT_W-1:0] len1;
    logic             div_tick;
    logic [1:0]       gnt;
    logic [1:0]       done;
    logic             aborted;
    logic             busy;
    logic             div_en;
    logic             div_sel;
    logic             div_clr;

    // Scheduler side
    modport slave (
        input  req, ratio0, ratio1, len0, len1, div_tick,
        output gnt, done, aborted, busy, div_en, div_sel, div_clr
    );

    // Client / divider side
    modport master (
        output req, ratio0, ratio1, len0, len1, div_tick,
        input  gnt, done, aborted, busy, div_en, div_sel, div_clr
    );
endinterface
`default_nettype wire

// File: rtl/div_sched.sv
`default_nettype none
// ============================================================================
//  Module   : div_sched
//  Purpose  : Round-robin scheduler sharing one divide-by-3/6 counter between
//             two requesters. Grants a run, clears and configures the divider,
//             enables it, counts returned ticks and reports completion.
//  Ports    : clk  - system clock, rising edge
//             rst  - asynchronous reset, active low
//             bus  - div_sched_if.slave (requests, lengths, ratios, divider
//                    tick in; grant, done, aborted, busy, divider controls out)
//  Revision : 1.0  initial release
// ============================================================================
module div_sched #(
    parameter int CNT_W = 8
) (
    input  wire logic    clk,
    input  wire logic    rst,
    div_sched_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CLR  = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           r_state,     w_state_nxt;
    logic             r_owner,     w_owner_nxt;
    logic             r_ratio,     w_ratio_nxt;
    logic             r_rr_last,   w_rr_last_nxt;
    logic             r_aborted,   w_aborted_nxt;
    logic [CNT_W-1:0] r_remaining, w_remaining_nxt;

    logic             w_win;
    logic             w_win_ratio;
    logic [CNT_W-1:0] w_win_len;

    // Arbitration: a lone request wins outright; on a tie the requester that
    // did not own the divider last time wins.
    always_comb begin
        w_win       = (bus.req == 2'b11) ? ~r_rr_last : bus.req[1];
        w_win_ratio = w_win ? bus.ratio1 : bus.ratio0;
        w_win_len   = w_win ? bus.len1   : bus.len0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_owner     <= 1'b0;
            r_ratio     <= 1'b0;
            r_rr_last   <= 1'b1;
            r_aborted   <= 1'b0;
            r_remaining <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_owner     <= w_owner_nxt;
            r_ratio     <= w_ratio_nxt;
            r_rr_last   <= w_rr_last_nxt;
            r_aborted   <= w_aborted_nxt;
            r_remaining <= w_remaining_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_owner_nxt     = r_owner;
        w_ratio_nxt     = r_ratio;
        w_rr_last_nxt   = r_rr_last;
        w_aborted_nxt   = 1'b0;
        w_remaining_nxt = r_remaining;

        unique case (r_state)
            IDLE: begin
                if (bus.req != 2'b00) begin
                    w_owner_nxt     = w_win;
                    w_ratio_nxt     = w_win_ratio;
                    w_remaining_nxt = w_win_len;
                    // A zero-length run completes without touching the divider.
                    w_state_nxt     = (w_win_len == '0) ? DONE : CLR;
                end
            end
            CLR: begin
                w_state_nxt = RUN;
            end
            RUN: begin
                // Owner withdrawal wins over a coincident final tick.
                if (!bus.req[r_owner]) begin
                    w_state_nxt   = IDLE;
                    w_aborted_nxt = 1'b1;
                    w_rr_last_nxt = r_owner;
                end else if (bus.div_tick) begin
                    if (r_remaining <= CNT_W'(1)) begin
                        w_state_nxt     = DONE;
                        w_remaining_nxt = '0;
                    end else begin
                        w_remaining_nxt = r_remaining - CNT_W'(1);
                    end
                end
            end
            DONE: begin
                w_rr_last_nxt = r_owner;
                w_state_nxt   = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Moore outputs: decoded only from registered state.
    always_comb begin
        bus.gnt     = 2'b00;
        bus.done    = 2'b00;
        bus.aborted = r_aborted;
        bus.busy    = (r_state != IDLE);
        bus.div_en  = (r_state == RUN);
        bus.div_clr = (r_state == CLR);
        bus.div_sel = 1'b0;
        if (r_state == CLR) begin
            bus.gnt = r_owner ? 2'b10 : 2'b01;
        end
        if (r_state == DONE) begin
            bus.done = r_owner ? 2'b10 : 2'b01;
        end
        if ((r_state == CLR) || (r_state == RUN)) begin
            bus.div_sel = r_ratio;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_div_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_div_sched
//  Purpose  : Directed self-checking bench for div_sched. Models a divider
//             that ticks on every 3rd enabled cycle and a client that drops
//             its request when its done pulse appears.
//  Revision : 1.0  initial release
// ============================================================================
module tb_div_sched;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    div_sched_if #(.CNT_W(8)) bus ();

    div_sched #(.CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    int   cyc_n, phase, ticks, gn, dn, ab_n, sel_bad, en_n, clr_n;
    int   drop_at_tick, drop_cyc;
    int   gseq [8];
    int   dseq [8];
    int   rereq_at [2];
    bit   rereq_en;
    logic last_owner;
    logic [1:0] gnt_l  [64];
    logic [1:0] done_l [64];
    logic       ab_l   [64];
    logic       en_l   [64];
    logic       clr_l  [64];
    logic       busy_l [64];
    logic       sel_l  [64];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Holds reset over two edges, checks the reset outputs, clears the bench
    // bookkeeping and releases reset #1 after an edge (that instant is cycle 0).
    task automatic do_reset;
        rst          = 1'b0;
        bus.req      = 2'b00;
        bus.div_tick = 1'b0;
        bus.ratio0   = 1'b0;
        bus.ratio1   = 1'b0;
        bus.len0     = 8'd0;
        bus.len1     = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_outs", {23'd0, bus.gnt, bus.done, bus.aborted, bus.busy,
                         bus.div_en, bus.div_sel, bus.div_clr}, 32'd0);
        cyc_n = 0; phase = 0; ticks = 0; gn = 0; dn = 0; ab_n = 0;
        sel_bad = 0; en_n = 0; clr_n = 0; drop_at_tick = 0; drop_cyc = 0;
        rereq_en = 1'b0; rereq_at[0] = -1; rereq_at[1] = -1; last_owner = 1'b0;
        for (int i = 0; i < 64; i++) begin
            gnt_l[i] = 2'b00; done_l[i] = 2'b00; ab_l[i] = 1'b0; en_l[i] = 1'b0;
            clr_l[i] = 1'b0; busy_l[i] = 1'b0; sel_l[i] = 1'b0;
        end
        for (int i = 0; i < 8; i++) begin
            gseq[i] = -1; dseq[i] = -1;
        end
        rst = 1'b1;
    endtask

    // One clock: sample outputs #1 after the edge, then drive client and
    // divider-model inputs for the coming edge.
    task automatic cyc;
        logic tick;
        @(posedge clk);
        #1;
        cyc_n++;
        if (cyc_n < 64) begin
            gnt_l[cyc_n]  = bus.gnt;   done_l[cyc_n] = bus.done;
            ab_l[cyc_n]   = bus.aborted; en_l[cyc_n] = bus.div_en;
            clr_l[cyc_n]  = bus.div_clr; busy_l[cyc_n] = bus.busy;
            sel_l[cyc_n]  = bus.div_sel;
        end
        if (bus.gnt != 2'b00) begin
            if (gn < 8) gseq[gn] = int'(bus.gnt[1]);
            gn++;
            last_owner = bus.gnt[1];
            if (gn >= 3) rereq_en = 1'b0;
        end
        if (bus.done != 2'b00) begin
            if (dn < 8) dseq[dn] = int'(bus.done[1]);
            dn++;
            bus.req[bus.done[1]] = 1'b0;
            if (rereq_en) rereq_at[bus.done[1]] = cyc_n + 2;
        end
        if (bus.aborted) ab_n++;
        if (bus.div_clr) clr_n++;
        if (bus.div_en) begin
            en_n++;
            if (bus.div_sel !== (last_owner ? bus.ratio1 : bus.ratio0)) sel_bad++;
        end
        for (int b = 0; b < 2; b++) begin
            if (rereq_en && rereq_at[b] == cyc_n) bus.req[b] = 1'b1;
        end
        if (bus.div_clr) phase = 0;
        tick = 1'b0;
        if (bus.div_en) begin
            phase++;
            if (phase == 3) begin
                tick  = 1'b1;
                phase = 0;
                ticks++;
            end
        end
        bus.div_tick = tick;
        if (drop_at_tick > 0 && tick && ticks == drop_at_tick) begin
            bus.req[0]   = 1'b0;
            drop_cyc     = cyc_n;
            drop_at_tick = 0;
        end
    endtask

    initial begin
        // ---- single run: requester 0, divide by 3, three ticks ----
        do_reset();
        bus.req = 2'b01; bus.ratio0 = 1'b0; bus.len0 = 8'd3;
        repeat (20) cyc();
        chk("t1_gnt_c1",   32'(gnt_l[1]), 32'd1);
        chk("t1_clr_c1",   32'(clr_l[1]), 32'd1);
        chk("t1_sel_c1",   32'(sel_l[1]), 32'd0);
        chk("t1_en_c1",    32'(en_l[1]),  32'd0);
        chk("t1_en_c2",    32'(en_l[2]),  32'd1);
        chk("t1_en_c10",   32'(en_l[10]), 32'd1);
        chk("t1_en_c11",   32'(en_l[11]), 32'd0);
        chk("t1_en_count", 32'(en_n),     32'd9);
        chk("t1_ticks",    32'(ticks),    32'd3);
        chk("t1_done_c11", 32'(done_l[11]), 32'd1);
        chk("t1_busy_c11", 32'(busy_l[11]), 32'd1);
        chk("t1_busy_c12", 32'(busy_l[12]), 32'd0);
        chk("t1_done_n",   32'(dn),       32'd1);

        // ---- tie from reset, round robin 0,1,0 ----
        do_reset();
        bus.req = 2'b11; bus.len0 = 8'd2; bus.len1 = 8'd2;
        bus.ratio0 = 1'b0; bus.ratio1 = 1'b1;
        rereq_en = 1'b1;
        repeat (35) cyc();
        chk("t2_g0",      32'(gseq[0]), 32'd0);
        chk("t2_g1",      32'(gseq[1]), 32'd1);
        chk("t2_g2",      32'(gseq[2]), 32'd0);
        chk("t2_gn",      32'(gn),      32'd3);
        chk("t2_d0",      32'(dseq[0]), 32'd0);
        chk("t2_d1",      32'(dseq[1]), 32'd1);
        chk("t2_d2",      32'(dseq[2]), 32'd0);
        chk("t2_gnt_c10", 32'(gnt_l[10]), 32'd2);
        chk("t2_sel_c10", 32'(sel_l[10]), 32'd1);
        chk("t2_sel_bad", 32'(sel_bad),  32'd0);

        // ---- zero length ----
        do_reset();
        bus.req = 2'b10; bus.len1 = 8'd0;
        repeat (6) cyc();
        chk("t3_done_c1", 32'(done_l[1]), 32'd2);
        chk("t3_busy_c2", 32'(busy_l[2]), 32'd0);
        chk("t3_gn",      32'(gn),        32'd0);
        chk("t3_clr_n",   32'(clr_n),     32'd0);
        chk("t3_en_n",    32'(en_n),      32'd0);

        // ---- abort after two ticks, pending requester 1 follows ----
        do_reset();
        bus.req = 2'b11; bus.len0 = 8'd5; bus.len1 = 8'd1;
        drop_at_tick = 2;
        repeat (30) cyc();
        chk("t4_dropped",  32'(drop_cyc > 0), 32'd1);
        chk("t4_en_drop",  32'(en_l[drop_cyc]), 32'd1);
        chk("t4_en_after", 32'(en_l[drop_cyc + 1]), 32'd0);
        chk("t4_ab_pulse", 32'(ab_l[drop_cyc + 1]), 32'd1);
        chk("t4_ab_n",     32'(ab_n), 32'd1);
        chk("t4_gnt1_cyc", 32'(gnt_l[drop_cyc + 2]), 32'd2);
        chk("t4_dn",       32'(dn), 32'd1);
        chk("t4_d0",       32'(dseq[0]), 32'd1);

        // ---- abort coincident with final tick ----
        do_reset();
        bus.req = 2'b01; bus.len0 = 8'd1;
        drop_at_tick = 1;
        repeat (12) cyc();
        chk("t5_ab_c5", 32'(ab_l[5]), 32'd1);
        chk("t5_ab_n",  32'(ab_n),    32'd1);
        chk("t5_dn",    32'(dn),      32'd0);

        // ---- async reset mid-run, then tie goes to requester 0 ----
        do_reset();
        bus.req = 2'b01; bus.len0 = 8'd6;
        repeat (9) cyc();
        chk("t6_en_before", 32'(en_l[9]), 32'd1);
        chk("t6_ticks",     32'(ticks),   32'd2);
        #2 rst = 1'b0;
        #1;
        chk("t6_en_async",   32'(bus.div_en), 32'd0);
        chk("t6_busy_async", 32'(bus.busy),   32'd0);
        chk("t6_gnt_async",  32'(bus.gnt),    32'd0);
        do_reset();
        bus.req = 2'b11; bus.len0 = 8'd2; bus.len1 = 8'd2;
        repeat (3) cyc();
        chk("t6_tie_g0", 32'(gseq[0]), 32'd0);
        chk("t6_gn",     32'(gn),      32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
